// File: rtl/spi_mem_pkg.sv
// Shared constants for the SPI serial-RAM responder: opcodes, address length
// and FSM state encodings.
package spi_mem_pkg;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;

    localparam int unsigned ADDR_BITS = 24;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CMD  = 3'd1;
    localparam logic [2:0] ST_ADDR = 3'd2;
    localparam logic [2:0] ST_RD   = 3'd3;
    localparam logic [2:0] ST_WR   = 3'd4;
    localparam logic [2:0] ST_SKIP = 3'd5;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronisers for the SPI pins, plus sclk edge pulses and a cs
// falling-edge pulse derived from the synchronised history.
module spi_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic mosi,
    input  logic cs,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic mosi_s,
    output logic cs_active,
    output logic cs_fall
);

    logic [2:0] r_sclk;
    logic [1:0] r_mosi;
    logic [2:0] r_cs;

    // cs history resets to "active" so a cs held low across reset cannot
    // open a frame; the pin has to go high first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sclk <= '0;
            r_mosi <= '0;
            r_cs   <= '0;
        end else begin
            r_sclk <= {r_sclk[1:0], sclk};
            r_mosi <= {r_mosi[0], mosi};
            r_cs   <= {r_cs[1:0], cs};
        end
    end

    assign sclk_rise = r_sclk[1] & ~r_sclk[2];
    assign sclk_fall = ~r_sclk[1] & r_sclk[2];
    assign mosi_s    = r_mosi[1];
    assign cs_active = ~r_cs[1];
    assign cs_fall   = r_cs[2] & ~r_cs[1];

endmodule

// File: rtl/spi_mem_responder.sv
// 23LC-style SPI serial-RAM responder (mode 0) backed by a preloadable byte array.
// Define SPI_MEM_WRITE_EN to accept the WRITE opcode; otherwise the array is read-only over SPI.
module spi_mem_responder
    import spi_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              cs,
    output logic              miso,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    output logic              busy
);

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_mosi;
    logic w_cs_active;
    logic w_cs_fall;
    logic [7:0] w_byte_in;

    logic [2:0]        r_state;
    logic [6:0]        r_shift;
    logic [4:0]        r_bitcnt;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_out;
    logic [2:0]        r_obit;
    logic              r_miso;
    logic              r_busy;
    logic [7:0]        r_mem [0:(1<<ADDR_W)-1];

    spi_sync_edge u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs        (cs),
        .sclk_rise (w_sclk_rise),
        .sclk_fall (w_sclk_fall),
        .mosi_s    (w_mosi),
        .cs_active (w_cs_active),
        .cs_fall   (w_cs_fall)
    );

    assign w_byte_in = {r_shift, w_mosi};

`ifdef SPI_MEM_WRITE_EN
    logic r_wr;
    logic w_spi_we;
    assign w_spi_we = rst_n && w_cs_active && (r_state == ST_WR) && w_sclk_rise
                      && (r_bitcnt == 5'd7);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_addr   <= '0;
            r_out    <= '0;
            r_obit   <= '0;
            r_miso   <= 1'b0;
            r_busy   <= 1'b0;
`ifdef SPI_MEM_WRITE_EN
            r_wr     <= 1'b0;
`endif
        end else begin
            r_busy <= w_cs_active;
            if (!w_cs_active) begin
                r_state  <= ST_IDLE;
                r_bitcnt <= '0;
                r_obit   <= '0;
                r_miso   <= 1'b0;
            end else begin
                if (r_state != ST_RD) r_miso <= 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        if (w_cs_fall) begin
                            r_state  <= ST_CMD;
                            r_bitcnt <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (w_sclk_rise) begin
                            r_shift <= w_byte_in[6:0];
                            if (r_bitcnt == 5'd7) begin
                                r_bitcnt <= '0;
                                if (w_byte_in == OP_READ) begin
                                    r_state <= ST_ADDR;
`ifdef SPI_MEM_WRITE_EN
                                    r_wr    <= 1'b0;
                                end else if (w_byte_in == OP_WRITE) begin
                                    r_state <= ST_ADDR;
                                    r_wr    <= 1'b1;
`endif
                                end else begin
                                    r_state <= ST_SKIP;
                                end
                            end else begin
                                r_bitcnt <= r_bitcnt + 5'd1;
                            end
                        end
                    end
                    ST_ADDR: begin
                        // Only the low ADDR_W bits survive the 24-bit shift.
                        if (w_sclk_rise) begin
                            r_addr <= {r_addr[ADDR_W-2:0], w_mosi};
                            if (r_bitcnt == 5'(ADDR_BITS - 1)) begin
                                r_bitcnt <= '0;
                                r_obit   <= '0;
`ifdef SPI_MEM_WRITE_EN
                                r_state  <= r_wr ? ST_WR : ST_RD;
`else
                                r_state  <= ST_RD;
`endif
                            end else begin
                                r_bitcnt <= r_bitcnt + 5'd1;
                            end
                        end
                    end
                    ST_RD: begin
                        // r_obit == 0 means the next fall starts a fresh byte.
                        if (w_sclk_fall) begin
                            if (r_obit == 3'd0) begin
                                r_miso <= r_mem[r_addr][7];
                                r_out  <= {r_mem[r_addr][6:0], 1'b0};
                                r_obit <= 3'd7;
                                r_addr <= r_addr + ADDR_W'(1);
                            end else begin
                                r_miso <= r_out[7];
                                r_out  <= {r_out[6:0], 1'b0};
                                r_obit <= r_obit - 3'd1;
                            end
                        end
                    end
`ifdef SPI_MEM_WRITE_EN
                    ST_WR: begin
                        if (w_sclk_rise) begin
                            r_shift <= w_byte_in[6:0];
                            if (r_bitcnt == 5'd7) begin
                                r_bitcnt <= '0;
                                r_addr   <= r_addr + ADDR_W'(1);
                            end else begin
                                r_bitcnt <= r_bitcnt + 5'd1;
                            end
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    // Preload is issued last so it wins over an SPI write to the same byte.
    always_ff @(posedge clk) begin
`ifdef SPI_MEM_WRITE_EN
        if (w_spi_we) r_mem[r_addr] <= w_byte_in;
`endif
        if (load_en) r_mem[load_addr] <= load_data;
    end

    assign miso = r_miso;
    assign busy = r_busy;

endmodule
